// File: rtl/oflow_arb_pkg.sv
// Shared definitions for the registration-port arbiter: FSM states, the
// address/data widths agreed with the PE, and the wait-counter width.
package oflow_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 112;

  // Wait counters must hold MAX_WAIT up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/oflow_arb_wait_cnt.sv
// Saturating wait counter for one requester: counts cycles spent asking
// without being served, stops at MAX_WAIT, and clears on grant or idle.
module oflow_arb_wait_cnt
  import oflow_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             reset_N,
  input  logic             req,
  input  logic             gnt,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  // Count unserved request cycles, holding at the starvation threshold.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_N)          count <= '0;
    else if (!req || gnt)  count <= '0;
    else if (count != MAX_CNT) count <= count + 1'b1;
  end

endmodule

// File: rtl/oflow_reg_arb.sv
// Arbiter for the single PE registration port shared by a write requester
// and a read requester. Each transaction occupies one bus cycle followed by
// an IDLE decision cycle. Ties go to write unless OFLOW_ARB_RR_EN is defined,
// in which case they alternate round-robin. A starvation guard forces a
// requester through once it has waited MAX_WAIT cycles.
module oflow_reg_arb
  import oflow_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              pe_EN,
  output logic              pe_wr,
  output logic [ADDR_W-1:0] pe_addr,
  output logic [DATA_W-1:0] pe_data_in,
  input  logic [DATA_W-1:0] pe_data_out,
  output logic              busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wr_wait, rd_wait;
  logic             wr_starved, rd_starved, tie_rd;

  oflow_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wr_wait (
    .clk     (clk),
    .reset_N (reset_N),
    .req     (wr_req),
    .gnt     (wr_gnt),
    .count   (wr_wait)
  );

  oflow_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_rd_wait (
    .clk     (clk),
    .reset_N (reset_N),
    .req     (rd_req),
    .gnt     (rd_gnt),
    .count   (rd_wait)
  );

  assign wr_starved = wr_req && (wr_wait == MAX_CNT);
  assign rd_starved = rd_req && (rd_wait == MAX_CNT);

`ifdef OFLOW_ARB_RR_EN
  // rr_rd set means the read side owns the next unforced tie.
  logic rr_rd;
  logic tie;

  assign tie    = (state == IDLE) && wr_req && rd_req && !wr_starved && !rd_starved;
  assign tie_rd = rr_rd;

  // Hand the next tie to the other requester after each tie is granted.
  always_ff @(posedge clk) begin
    if (!reset_N)  rr_rd <= 1'b0;
    else if (tie)  rr_rd <= !rr_rd;
  end
`else
  assign tie_rd = 1'b0;
`endif

  // Next-state decision: read wins when it is alone, starved, or owns the
  // tie and write is not starved; otherwise any write request wins.
  // NOTE: state_nxt is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (rd_req && (!wr_req || rd_starved || (!wr_starved && tie_rd)))
          state_nxt = READ;
        else if (wr_req)
          state_nxt = WRITE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the bus payload captured at the IDLE decision.
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      state      <= IDLE;
      rd_valid   <= 1'b0;
      pe_addr    <= '0;
      pe_data_in <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= (state == READ);
      if (state_nxt == WRITE) begin
        pe_addr    <= wr_addr;
        pe_data_in <= wr_data;
      end else if (state_nxt == READ) begin
        pe_addr <= rd_addr;
      end
    end
  end

  assign wr_gnt  = (state == WRITE);
  assign rd_gnt  = (state == READ);
  assign pe_EN   = wr_gnt || rd_gnt;
  assign pe_wr   = wr_gnt;
  assign busy    = (state != IDLE);
  // Gated so rd_data reads zero outside its valid cycle and under reset.
  assign rd_data = rd_valid ? pe_data_out : '0;

endmodule

// File: tb/tb_oflow_reg_arb.sv
// Self-checking bench for oflow_reg_arb: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_oflow_reg_arb;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 112;
  localparam int MAX_WAIT = 4;

  localparam int T_NONE = 0;
  localparam int T_WR   = 1;
  localparam int T_RD   = 2;

  logic              clk = 1'b0;
  logic              reset_N;
  logic              wr_req, rd_req;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt, rd_gnt, rd_valid, pe_EN, pe_wr, busy;
  logic [DATA_W-1:0] rd_data, pe_data_in, pe_data_out;
  logic [ADDR_W-1:0] pe_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oflow_reg_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .reset_N     (reset_N),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .pe_EN       (pe_EN),
    .pe_wr       (pe_wr),
    .pe_addr     (pe_addr),
    .pe_data_in  (pe_data_in),
    .pe_data_out (pe_data_out),
    .busy        (busy)
  );

  function automatic logic [DATA_W-1:0] init_pat(int a);
    logic [7:0] b;
    b = 8'(a) ^ 8'h3C;
    return {14{b}};
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return DATA_W'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // PE register file: writes on a write command, answers a read command the
  // following cycle, and drives noise at every other time.
  logic [DATA_W-1:0] pe_mem   [256];
  bit                pe_wrote [256];
  always @(posedge clk) begin
    if (pe_EN && pe_wr) begin
      pe_mem[pe_addr]   = pe_data_in;
      pe_wrote[pe_addr] = 1'b1;
    end
    if (pe_EN && !pe_wr)
      pe_data_out <= pe_wrote[pe_addr] ? pe_mem[pe_addr] : init_pat(int'(pe_addr));
    else
      pe_data_out <= rnd_data();
  end

  // Reference model: which transaction is on the bus, what it carries, the
  // expected read-back, and the per-requester waiting time.
  int                m_bus = T_NONE;
  int                m_wc = 0, m_rc = 0;
  bit                m_ptr_rd = 1'b0;
  bit                m_rdv = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_din = '0, m_rdata = '0, m_rdpend = '0;
  logic [DATA_W-1:0] m_mem   [256];
  bit                m_wrote [256];

  task automatic model_step();
    int pick, nwc, nrc;
    if (!reset_N) begin
      m_bus = T_NONE; m_wc = 0; m_rc = 0; m_ptr_rd = 1'b0;
      m_rdv = 1'b0; m_rdata = '0; m_addr = '0; m_din = '0;
      return;
    end
    m_rdv   = (m_bus == T_RD);
    m_rdata = m_rdv ? m_rdpend : '0;
    nwc = (wr_req && m_bus != T_WR) ? ((m_wc + 1 > MAX_WAIT) ? MAX_WAIT : m_wc + 1) : 0;
    nrc = (rd_req && m_bus != T_RD) ? ((m_rc + 1 > MAX_WAIT) ? MAX_WAIT : m_rc + 1) : 0;
    pick = T_NONE;
    if (m_bus == T_NONE) begin
      if (wr_req && rd_req) begin
        if (m_rc == MAX_WAIT)      pick = T_RD;
        else if (m_wc == MAX_WAIT) pick = T_WR;
        else begin
`ifdef OFLOW_ARB_RR_EN
          pick = m_ptr_rd ? T_RD : T_WR;
          m_ptr_rd = !m_ptr_rd;
`else
          pick = T_WR;
`endif
        end
      end else if (wr_req) pick = T_WR;
      else if (rd_req)     pick = T_RD;
    end
    if (pick == T_WR) begin
      m_addr = wr_addr; m_din = wr_data;
      m_mem[wr_addr] = wr_data; m_wrote[wr_addr] = 1'b1;
    end else if (pick == T_RD) begin
      m_addr   = rd_addr;
      m_rdpend = m_wrote[rd_addr] ? m_mem[rd_addr] : init_pat(int'(rd_addr));
    end
    m_bus = pick; m_wc = nwc; m_rc = nrc;
  endtask

  // Advance one clock; outputs are then inspected at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_N = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 8'h33; rd_addr = 8'h44; wr_data = rnd_data();
    cycle(); cycle();
    checks++;
    if ({wr_gnt, rd_gnt, pe_EN, pe_wr, rd_valid, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {wr_gnt, rd_gnt, pe_EN, pe_wr, rd_valid, busy});
    checks++;
    if (pe_addr !== '0 || pe_data_in !== '0 || rd_data !== '0)
      $display("FAIL reset_data: got addr %h din %h rdata %h expected all zero", pe_addr, pe_data_in, rd_data);
    if (pe_addr !== '0 || pe_data_in !== '0 || rd_data !== '0 ||
        {wr_gnt, rd_gnt, pe_EN, pe_wr, rd_valid, busy} !== 6'b0) errors++;
    reset_N = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    cycle();
  endtask

  task automatic test_single_write();
    wr_req = 1'b1; wr_addr = 8'h05; wr_data = {14{8'hA5}};
    cycle();
    checks++;
    if ({wr_gnt, rd_gnt, pe_EN, pe_wr, busy} !== 5'b10111) begin
      errors++;
      $display("FAIL write_strobes: got %b expected 10111", {wr_gnt, rd_gnt, pe_EN, pe_wr, busy});
    end
    checks++;
    if (pe_addr !== 8'h05 || pe_data_in !== {14{8'hA5}}) begin
      errors++;
      $display("FAIL write_payload: got %h/%h expected 05/%h", pe_addr, pe_data_in, {14{8'hA5}});
    end
    wr_req = 1'b0;
    cycle();
    checks++;
    if ({wr_gnt, pe_EN, pe_wr, busy} !== 4'b0 || pe_addr !== 8'h05) begin
      errors++;
      $display("FAIL write_return_idle: got %b addr %h expected 0000 addr 05", {wr_gnt, pe_EN, pe_wr, busy}, pe_addr);
    end
  endtask

  task automatic test_write_read();
    wr_req = 1'b1; wr_addr = 8'h07; wr_data = 112'h12;
    cycle();
    checks++;
    if (wr_gnt !== 1'b1) begin errors++; $display("FAIL wr7_gnt: got %b expected 1", wr_gnt); end
    wr_req = 1'b0;
    cycle();
    rd_req = 1'b1; rd_addr = 8'h07;
    cycle();
    checks++;
    if ({rd_gnt, wr_gnt, pe_EN, pe_wr} !== 4'b1010 || pe_addr !== 8'h07 || pe_data_in !== 112'h12) begin
      errors++;
      $display("FAIL rd7_cmd: got %b addr %h din %h expected 1010 addr 07 din 12", {rd_gnt, wr_gnt, pe_EN, pe_wr}, pe_addr, pe_data_in);
    end
    rd_req = 1'b0;
    cycle();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 112'h12 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd7_data: got valid %b data %h busy %b expected 1 12 0", rd_valid, rd_data, busy);
    end
    cycle();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL rd7_valid_once: got valid %b data %h expected 0 0", rd_valid, rd_data);
    end
  endtask

  task automatic test_both_held();
    int seq[$];
    int run, max_run, nreads;
    reset_N = 1'b0; cycle(); reset_N = 1'b1;
    wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 8'h80 | 8'($urandom_range(0, 127)); wr_data = rnd_data();
    rd_addr = 8'h80 | 8'($urandom_range(0, 127));
    for (int i = 0; i < 24; i++) begin
      cycle();
      checks++;
      if (wr_gnt !== (m_bus == T_WR) || rd_gnt !== (m_bus == T_RD)) begin
        errors++;
        $display("FAIL held_model c%0d: got w%b r%b expected w%b r%b", i, wr_gnt, rd_gnt, m_bus == T_WR, m_bus == T_RD);
      end
      if (wr_gnt === 1'b1) seq.push_back(T_WR);
      if (rd_gnt === 1'b1) seq.push_back(T_RD);
    end
    checks++;
    if (seq.size() != 12) begin
      errors++;
      $display("FAIL held_throughput: got %0d grants expected 12", seq.size());
    end
`ifdef OFLOW_ARB_RR_EN
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (seq[i] != ((i % 2 == 0) ? T_WR : T_RD)) begin
        errors++;
        $display("FAIL rr_alternate g%0d: got %0d expected %0d", i, seq[i], (i % 2 == 0) ? T_WR : T_RD);
      end
    end
`else
    run = 0; max_run = 0; nreads = 0;
    foreach (seq[i]) begin
      if (seq[i] == T_WR) begin run++; if (run > max_run) max_run = run; end
      else begin run = 0; nreads++; end
    end
    checks++;
    if (max_run > MAX_WAIT || nreads < 12 / (MAX_WAIT + 1)) begin
      errors++;
      $display("FAIL fixed_starvation: got max write run %0d reads %0d expected run<=%0d reads>=%0d", max_run, nreads, MAX_WAIT, 12 / (MAX_WAIT + 1));
    end
`endif
    wr_req = 1'b0; rd_req = 1'b0;
    cycle(); cycle();
  endtask

  task automatic test_reset_in_read();
    bit got, early_valid;
    int n;
    rd_req = 1'b1; rd_addr = 8'h07;
    cycle();
    checks++;
    if (rd_gnt !== 1'b1) begin errors++; $display("FAIL cut_read_gnt: got %b expected 1", rd_gnt); end
    reset_N = 1'b0;
    cycle();
    checks++;
    if ({wr_gnt, rd_gnt, pe_EN, pe_wr, rd_valid, busy} !== 6'b0 || pe_addr !== '0 || pe_data_in !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL cut_read_outputs: got %b addr %h rdata %h expected all zero", {wr_gnt, rd_gnt, pe_EN, pe_wr, rd_valid, busy}, pe_addr, rd_data);
    end
    reset_N = 1'b1;
    got = 1'b0; early_valid = 1'b0; n = 0;
    for (int i = 0; i < 2 && !got; i++) begin
      cycle();
      n++;
      if (rd_valid === 1'b1) early_valid = 1'b1;
      if (rd_gnt === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || early_valid) begin
      errors++;
      $display("FAIL cut_read_regrant: got gnt %b stray valid %b after %0d cycles expected gnt 1 valid 0", got, early_valid, n);
    end
    rd_req = 1'b0;
    cycle();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 112'h12) begin
      errors++;
      $display("FAIL cut_read_retry_data: got %b %h expected 1 12", rd_valid, rd_data);
    end
  endtask

  task automatic test_random();
    bit rst_next;
    for (int i = 0; i < 600; i++) begin
      cycle();
      checks++;
      if ({wr_gnt, rd_gnt, pe_EN, pe_wr, busy, rd_valid} !==
          {m_bus == T_WR, m_bus == T_RD, m_bus != T_NONE, m_bus == T_WR, m_bus != T_NONE, m_rdv}) begin
        errors++;
        $display("FAIL rand_ctrl c%0d: got %b expected %b", i, {wr_gnt, rd_gnt, pe_EN, pe_wr, busy, rd_valid},
                 {m_bus == T_WR, m_bus == T_RD, m_bus != T_NONE, m_bus == T_WR, m_bus != T_NONE, m_rdv});
      end
      checks++;
      if (pe_addr !== m_addr || pe_data_in !== m_din || rd_data !== m_rdata) begin
        errors++;
        $display("FAIL rand_data c%0d: got %h/%h/%h expected %h/%h/%h", i, pe_addr, pe_data_in, rd_data, m_addr, m_din, m_rdata);
      end
      // Requesters: a grant that is not cut by reset completes the request.
      rst_next = ($urandom_range(0, 49) == 0);
      if (wr_req ? (wr_gnt && !rst_next) : ($urandom_range(0, 3) != 0)) begin
        wr_req  = wr_req ? 1'($urandom_range(0, 1)) : 1'b1;
        wr_addr = 8'($urandom_range(0, 15)); wr_data = rnd_data();
      end
      if (rd_req ? (rd_gnt && !rst_next) : ($urandom_range(0, 3) != 0)) begin
        rd_req  = rd_req ? 1'($urandom_range(0, 1)) : 1'b1;
        rd_addr = 8'($urandom_range(0, 15));
      end
      reset_N = !rst_next;
    end
    reset_N = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    reset_N = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    test_reset();
    test_single_write();
    test_write_read();
    test_both_held();
    test_reset_in_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
